// File: rtl/io_pkg.sv
// Shared definitions for the key I/O region: receive FSM states, rdata bit map,
// pop address and receive timeout. Parity helper exists only with KEY_PARITY_CHECK_EN.
package io_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

    localparam int VALID = 15;
    localparam int OVF   = 14;
    localparam int FERR  = 13;

    localparam logic [15:0] KEY_POP_ADDR = 16'h0000;
    localparam logic [15:0] KEY_TIMEOUT  = 16'hFFFF;

`ifdef KEY_PARITY_CHECK_EN
    // PS/2 uses odd parity: data bits plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction
`endif

endpackage

// File: rtl/key_fifo.sv
// Scancode FIFO: power-of-two depth, wrapping pointers, head reads as zero when empty.
// A pop frees a slot in the same cycle, so a push into a full FIFO with a pop succeeds.
module key_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    rd_ptr_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == {CW{1'b0}});
    assign pop_ok_s  = pop_i & ~empty_o;
    assign push_ok_s = push_i & (~full_o | pop_ok_s);
    assign head_o    = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; stale entries are never visible because head is gated by empty.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/key_io_device.sv
// PS/2 keyboard receiver exposed as a memory-mapped status/data word.
// Define KEY_PARITY_CHECK_EN to reject frames with bad odd parity.
module key_io_device
    import io_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic [15:0] waddr,
    input  logic [15:0] wdata,
    input  logic        wenable,
    output logic [15:0] rdata
);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_prev_q;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall_s;

    rx_state_e   state_q;
    rx_state_e   state_d;
    logic [2:0]  bit_cnt_q;
    logic [2:0]  bit_cnt_d;
    logic [7:0]  shift_q;
    logic [7:0]  shift_d;
    logic [15:0] tmo_q;
    logic [15:0] tmo_d;
`ifdef KEY_PARITY_CHECK_EN
    logic        par_q;
    logic        par_d;
`endif

    logic        ovf_q;
    logic        ovf_d;
    logic        ferr_q;
    logic        ferr_d;
    logic        frame_ok_s;
    logic        push_s;
    logic        ferr_set_s;
    logic        pop_s;
    logic        clr_s;
    logic        ovf_set_s;
    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic [7:0]  fifo_head_s;
    logic        unused_wdata_s;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];
    assign fall_s = clk_prev_q & ~clk_s;

    assign pop_s          = wenable & (waddr == KEY_POP_ADDR);
    assign clr_s          = pop_s & wdata[15];
    assign unused_wdata_s = ^wdata[14:0];

    // Synchronizers idle high so reset release never looks like a falling edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= {SYNC_STAGES{1'b1}};
            data_sync_q <= {SYNC_STAGES{1'b1}};
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            clk_prev_q  <= clk_s;
        end
    end

    // Frame acceptance: parity is only consulted when the check is built in.
    always_comb begin
`ifdef KEY_PARITY_CHECK_EN
        frame_ok_s = odd_parity_ok(shift_q, par_q);
`else
        frame_ok_s = 1'b1;
`endif
    end

    // Receive FSM next-state; the timeout counter saturates and only fires outside IDLE.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tmo_d      = tmo_q;
        push_s     = 1'b0;
        ferr_set_s = 1'b0;
`ifdef KEY_PARITY_CHECK_EN
        par_d      = par_q;
`endif
        if (fall_s) begin
            tmo_d = 16'h0000;
            case (state_q)
                IDLE: begin
                    if (!data_s) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DATA: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end else begin
                        state_d = DATA;
                    end
                end
                PARITY: begin
`ifdef KEY_PARITY_CHECK_EN
                    par_d = data_s;
`endif
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (data_s && frame_ok_s) begin
                        push_s = 1'b1;
                    end else begin
                        ferr_set_s = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (tmo_q == KEY_TIMEOUT) begin
            state_d = IDLE;
            if (state_q != IDLE) begin
                ferr_set_s = 1'b1;
            end else begin
                ferr_set_s = 1'b0;
            end
        end else begin
            tmo_d = tmo_q + 16'd1;
        end
    end

    // Receive FSM and timeout registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            tmo_q     <= 16'h0000;
`ifdef KEY_PARITY_CHECK_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tmo_q     <= tmo_d;
`ifdef KEY_PARITY_CHECK_EN
            par_q     <= par_d;
`endif
        end
    end

    // A byte is dropped only when full and no pop frees a slot this cycle.
    assign ovf_set_s = push_s & fifo_full_s & ~(pop_s & ~fifo_empty_s);

    // Sticky flags: a new event in the clearing cycle still wins.
    always_comb begin
        ovf_d  = ovf_set_s | (ovf_q & ~clr_s);
        ferr_d = ferr_set_s | (ferr_q & ~clr_s);
    end

    // Flag registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            ferr_q <= ferr_d;
        end
    end

    key_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clock),
        .rst_ni      (reset_n),
        .push_i      (push_s),
        .push_data_i (shift_q),
        .pop_i       (pop_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s),
        .head_o      (fifo_head_s)
    );

    // Read word assembled from registered state only.
    always_comb begin
        rdata        = 16'h0000;
        rdata[VALID] = ~fifo_empty_s;
        rdata[OVF]   = ovf_q;
        rdata[FERR]  = ferr_q;
        rdata[7:0]   = fifo_head_s;
    end

endmodule

// File: tb/tb_key_io_device.sv
// Randomized and directed bench for key_io_device against a queue-based model.
// PS/2 runs at 10 kHz against a 200 kHz system clock (20 system cycles per bit).
`timescale 1ns/1ps
module tb_key_io_device;
    import io_pkg::*;

    localparam int DEPTH = 8;
    localparam int HALF  = 10;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] waddr   = 16'h0000;
    logic [15:0] wdata   = 16'h0000;
    logic        wenable = 1'b0;
    logic [15:0] rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_q[$];
    logic       m_ovf  = 1'b0;
    logic       m_ferr = 1'b0;

    key_io_device #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .waddr    (waddr),
        .wdata    (wdata),
        .wenable  (wenable),
        .rdata    (rdata)
    );

    always #2500 clock = ~clock;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_rdata();
        logic [15:0] r;
        r = 16'h0000;
        if (model_q.size() > 0) begin
            r[15]  = 1'b1;
            r[7:0] = model_q[0];
        end
        r[14] = m_ovf;
        r[13] = m_ferr;
        return r;
    endfunction

    function automatic logic odd_par(input logic [7:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    function automatic logic frame_parity_ok(input logic [7:0] d, input logic p);
`ifdef KEY_PARITY_CHECK_EN
        return ($countones({d, p}) % 2) == 1;
`else
        return 1'b1;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_partial(input int nbits);
        ps2_bit(1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(logic'($urandom_range(0, 1)));
    endtask

    // Full frame; the stop edge is checked cycle-accurately, optionally with a pop on it.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop, input logic pop_at_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(p);
        ps2_data = stop;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(2);
        check_eq("pre_push", rdata, model_rdata());
        if (pop_at_stop) begin
            waddr   = 16'h0000;
            wdata   = 16'h0000;
            wenable = 1'b1;
        end
        tick(1);
        wenable = 1'b0;
        if (pop_at_stop && model_q.size() > 0) void'(model_q.pop_front());
        if (!stop || !frame_parity_ok(d, p)) m_ferr = 1'b1;
        else if (model_q.size() == DEPTH) m_ovf = 1'b1;
        else model_q.push_back(d);
        check_eq("stop_edge", rdata, model_rdata());
        tick(HALF - 3);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        tick(2);
    endtask

    task automatic write_reg(input logic [15:0] a, input logic [15:0] d);
        waddr   = a;
        wdata   = d;
        wenable = 1'b1;
        tick(1);
        wenable = 1'b0;
        if (a == 16'h0000) begin
            if (model_q.size() > 0) void'(model_q.pop_front());
            if (d[15]) begin
                m_ovf  = 1'b0;
                m_ferr = 1'b0;
            end
        end
        check_eq("write", rdata, model_rdata());
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(3);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        model_q.delete();
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
        check_eq("in_reset", rdata, 16'h0000);
        reset_n = 1'b1;
        tick(3);
        check_eq("post_reset", rdata, 16'h0000);
    endtask

    initial begin
        logic [7:0] d;
        logic [15:0] a;
        tick(1);
        do_reset();

        // Single frame, then pop
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        check_eq("frame_1c", rdata, 16'h801C);
        write_reg(16'h0000, 16'h0000);
        check_eq("pop_1c", rdata, 16'h0000);

        // Overflow on the ninth frame
        for (int i = 1; i <= 9; i++) send_frame(8'(i), odd_par(8'(i)), 1'b1, 1'b0);
        check_eq("ovf_set", {15'h0000, rdata[14]}, 16'h0001);
        for (int i = 1; i <= 8; i++) begin
            check_eq("ovf_order", {8'h00, rdata[7:0]}, 16'(i));
            write_reg(16'h0000, 16'h0000);
        end
        check_eq("ovf_empty", rdata, 16'h4000);
        write_reg(16'h0000, 16'h8000);

        // Bad stop bit
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        check_eq("bad_stop", rdata, 16'h2000);
        write_reg(16'h0000, 16'h8000);
        check_eq("clr_ferr", rdata, 16'h0000);

        // Wrong parity
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
`ifdef KEY_PARITY_CHECK_EN
        check_eq("bad_par", rdata, 16'h2000);
`else
        check_eq("bad_par", rdata, 16'h801C);
`endif
        write_reg(16'h0000, 16'h8000);

        // Stalled partial frame must time out into IDLE with frame_err
        send_partial(4);
        tick(64000);
        check_eq("pre_timeout", rdata, model_rdata());
        tick(1600);
        m_ferr = 1'b1;
        check_eq("tmo_state", 16'(dut.state_q), 16'(IDLE));
        check_eq("tmo_ferr", rdata, 16'h2000);
        send_frame(8'h5A, odd_par(8'h5A), 1'b1, 1'b0);
        check_eq("after_tmo", {8'h00, rdata[7:0]}, 16'h005A);
        write_reg(16'h0000, 16'h8000);

        // Full FIFO, push of F0 with a simultaneous pop
        for (int i = 0; i < DEPTH; i++) begin
            d = 8'($urandom_range(0, 255));
            send_frame(d, odd_par(d), 1'b1, 1'b0);
        end
        send_frame(8'hF0, odd_par(8'hF0), 1'b1, 1'b1);
        check_eq("pp_noovf", {15'h0000, rdata[14]}, 16'h0000);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) check_eq("pp_last", {8'h00, rdata[7:0]}, 16'h00F0);
            write_reg(16'h0000, 16'h0000);
        end
        check_eq("pp_empty", rdata, 16'h0000);

        // Reset in the middle of a frame
        send_frame(8'h33, odd_par(8'h33), 1'b1, 1'b0);
        send_partial(3);
        do_reset();
        tick(40);
        check_eq("rst_nopush", rdata, 16'h0000);
        send_frame(8'hA5, odd_par(8'hA5), 1'b1, 1'b0);
        check_eq("rst_frame", rdata, 16'h80A5);

        // Randomized traffic
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 9) < 6) begin
                d = 8'($urandom_range(0, 255));
                send_frame(d, ($urandom_range(0, 7) == 0) ? ~odd_par(d) : odd_par(d),
                           ($urandom_range(0, 7) != 0), logic'($urandom_range(0, 1)));
            end else begin
                a = ($urandom_range(0, 2) != 0) ? 16'h0000 : 16'($urandom_range(1, 65535));
                write_reg(a, 16'($urandom_range(0, 65535)));
            end
            tick(1);
            check_eq("rand", rdata, model_rdata());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_io_device.md
KEY_IO_DEVICE -- requirements
Module: key_io_device

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, sets scancode FIFO depth; the value SHALL be a power of two in the range 2..64.
REQ-002 Parameter SYNC_STAGES, default 2, sets the synchronizer depth applied to ps2_clk and ps2_data.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 Port clock, input, 1 bit: system clock, same clock the memory controller drives onto key_io.clock.
REQ-005 Port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port ps2_clk, input, 1 bit: raw PS/2 clock from the keyboard, asynchronous to clock.
REQ-007 Port ps2_data, input, 1 bit: raw PS/2 data from the keyboard, asynchronous to clock.
REQ-008 Port waddr, input, 16 bits: io write offset from the memory controller.
REQ-009 Port wdata, input, 16 bits: io write data.
REQ-010 Port wenable, input, 1 bit: io write strobe.
REQ-011 Port rdata, output, 16 bits: status/data word returned for reads of the key I/O region.

Function
REQ-012 ps2_clk and ps2_data SHALL each pass through SYNC_STAGES flops; a falling edge is the synchronized value going from 1 to 0.
REQ-013 Receive FSM states SHALL be IDLE, DATA, PARITY and STOP; all transitions occur only on a synchronized ps2_clk falling edge or on timeout.
REQ-014 IDLE: sampled data 0 (start bit) -> DATA with bit count cleared; sampled data 1 -> remain in IDLE.
REQ-015 DATA: shift the sampled bit in LSB-first; after the 8th bit -> PARITY.
REQ-016 PARITY: capture the parity bit -> STOP.
REQ-017 STOP: on stop=1 with a valid frame, push the byte; on stop=0, discard the frame and set frame_err; both cases -> IDLE.
REQ-018 Timeout: a 16-bit counter resets on every falling edge; if it reaches 0xFFFF while the FSM is not in IDLE, the FSM SHALL return to IDLE, discard the partial frame and set frame_err.
REQ-019 rdata SHALL be {fifo_nonempty, overflow, frame_err, 5'b0, head_byte}; head_byte is 8'h00 when the FIFO is empty.
REQ-020 rdata SHALL be combinational from the registered FIFO head and flags, so it is valid in the same cycle the memory controller samples it.
REQ-021 wenable=1 with waddr==16'h0000 SHALL pop one entry if the FIFO is nonempty; a pop on an empty FIFO has no effect.
REQ-022 wenable=1 with waddr==16'h0000 and wdata[15]=1 SHALL additionally clear overflow and frame_err.
REQ-023 Writes to any other waddr SHALL be ignored.
REQ-024 A push into a full FIFO SHALL drop the new byte and set overflow; the FIFO contents are unchanged.
REQ-025 A simultaneous push and pop SHALL both take effect: the occupancy count is unchanged, and a push into a full FIFO with a simultaneous pop succeeds.
REQ-026 A push to an empty FIFO SHALL be visible on rdata exactly 1 cycle after the STOP-edge cycle.
REQ-027 FIFO pointers are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH; the count is log2(FIFO_DEPTH)+1 bits wide.
REQ-028 Flags overflow and frame_err are sticky until cleared per REQ-022.

Reset
REQ-029 On reset_n=0: FSM -> IDLE, FIFO empty, all flags 0, synchronizers -> 1, timeout counter -> 0, rdata -> 16'h0000.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; no push occurs after reset release until a new start bit is received.

Configuration
REQ-031 Macro KEY_PARITY_CHECK_EN defined: a frame is valid only if its odd parity over data+parity is correct; a frame failing parity SHALL be discarded and set frame_err.
REQ-032 KEY_PARITY_CHECK_EN undefined: the parity bit is captured but ignored; no parity logic is synthesized.

Structure
REQ-033 A shared package io_pkg SHALL hold the FSM state enum, the rdata bit-position constants (VALID=15, OVF=14, FERR=13), KEY_POP_ADDR=16'h0000 and the timeout constant.
REQ-034 The FIFO SHALL be a separate sub-module key_fifo, parameterized by width 8 and FIFO_DEPTH, with push/pop/full/empty/head ports.

Verification
REQ-035 Bench SHALL send frame 0x1C (parity 0, stop 1) at 10 kHz, then check rdata==16'h801C; a pop then yields rdata==16'h0000.
REQ-036 Bench SHALL send 9 frames 0x01..0x09 with no pops (depth 8), then check overflow=1; pops return 0x01..0x08 in order, then the FIFO is empty.
REQ-037 Bench SHALL send frame 0x1C with stop bit 0, then check no push and rdata==16'h2000; a write of wdata=16'h8000 to waddr 0 then yields rdata==16'h0000.
REQ-038 With KEY_PARITY_CHECK_EN, bench SHALL send 0x1C with parity 1, then check it is discarded and frame_err=1; without the macro, bench SHALL check the byte is pushed.
REQ-039 Bench SHALL send a start bit plus 4 bits and then stall ps2_clk; after 65535 cycles check FSM=IDLE and frame_err=1, then a full frame 0x5A gives rdata[7:0]==8'h5A.
REQ-040 Bench SHALL pre-fill the FIFO to full, then pop in the same cycle as a push of 0xF0; check overflow=0, count=8 and 0xF0 as the last entry.
